// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit: single-cycle MULT/MULTU, 32-step restoring DIV/DIVU.
// Produces {hi, lo} with a one-cycle valid pulse; busy covers every non-IDLE state.
module hilo_muldiv_unit #(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic        valid,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  dbg_state
);

  // Handshake: start is taken only in IDLE with cancel low; the result is
  // announced by a single-cycle valid pulse and no backpressure exists.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int CW = $clog2(DIV_ITERS);
  localparam logic [CW-1:0] LAST_ITER = CW'(DIV_ITERS - 1);

  state_t        state;
  logic [1:0]    op_r;
  logic [31:0]   a_r;
  logic [31:0]   b_r;
  logic [31:0]   rem;
  logic [31:0]   quo;
  logic [31:0]   dvsr;
  logic          q_neg;
  logic          r_neg;
  logic          div_zero;
  logic [CW-1:0] count;

  logic          is_signed_div;
  logic [31:0]   mag_a;
  logic [31:0]   mag_b;
  logic [63:0]   ext_a;
  logic [63:0]   ext_b;
  logic [63:0]   prod;
  logic [32:0]   rem_sh;
  logic [32:0]   diff;
  logic [31:0]   step_rem;
  logic [31:0]   step_quo;
  logic [31:0]   fin_rem;
  logic [31:0]   fin_quo;

  assign dbg_state = state;

  always_comb begin
    is_signed_div = ~op[0];
    mag_a = (is_signed_div && a[31]) ? (~a + 32'd1) : a;
    mag_b = (is_signed_div && b[31]) ? (~b + 32'd1) : b;
  end

  // The low 64 bits of the extended product are exact for both signednesses.
  always_comb begin
    ext_a = op_r[0] ? {32'b0, a_r} : {{32{a_r[31]}}, a_r};
    ext_b = op_r[0] ? {32'b0, b_r} : {{32{b_r[31]}}, b_r};
    prod  = ext_a * ext_b;
  end

  // One restoring step: rem < dvsr keeps the 33-bit difference in signed range.
  always_comb begin
    rem_sh = {rem, quo[31]};
    diff   = rem_sh - {1'b0, dvsr};
    if (!diff[32]) begin
      step_rem = diff[31:0];
      step_quo = {quo[30:0], 1'b1};
    end else begin
      step_rem = rem_sh[31:0];
      step_quo = {quo[30:0], 1'b0};
    end
    fin_quo = q_neg ? (~step_quo + 32'd1) : step_quo;
    fin_rem = r_neg ? (~step_rem + 32'd1) : step_rem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      valid    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      count    <= '0;
      op_r     <= '0;
      a_r      <= '0;
      b_r      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !cancel) begin
            op_r     <= op;
            a_r      <= a;
            b_r      <= b;
            rem      <= '0;
            quo      <= mag_a;
            dvsr     <= mag_b;
            q_neg    <= is_signed_div & (a[31] ^ b[31]);
            r_neg    <= is_signed_div & a[31];
            div_zero <= (b == 32'd0);
            count    <= '0;
            busy     <= 1'b1;
            state    <= op[1] ? S_DIV : S_MUL;
          end
        end
        S_MUL: begin
          if (cancel) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            {hi, lo} <= prod;
            valid    <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DIV: begin
          if (cancel) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (div_zero) begin
            hi    <= a_r;
            lo    <= 32'hFFFF_FFFF;
            valid <= 1'b1;
            state <= S_DONE;
          end else begin
            rem   <= step_rem;
            quo   <= step_quo;
            count <= count + 1'b1;
            if (count == LAST_ITER) begin
              hi    <= fin_rem;
              lo    <= fin_quo;
              valid <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: hand-computed products, quotients,
// remainders, latencies, cancel/reset behaviour and held-start throughput.
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic        valid;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  hilo_muldiv_unit #(.DIV_ITERS(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .cancel    (cancel),
    .busy      (busy),
    .valid     (valid),
    .hi        (hi),
    .lo        (lo),
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Issue one operation from IDLE and follow it to its valid pulse.
  task automatic run_op(input string tag, input logic [1:0] op_v, input logic [31:0] a_v,
                        input logic [31:0] b_v, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_lat);
    int cyc;
    int busy_cnt;
    bit got;
    start = 1'b1;
    op    = op_v;
    a     = a_v;
    b     = b_v;
    tick();
    start    = 1'b0;
    a        = $urandom;
    b        = $urandom;
    busy_cnt = busy ? 1 : 0;
    cyc      = 0;
    got      = 1'b0;
    while (!got && cyc < 40) begin
      tick();
      cyc++;
      if (busy) busy_cnt++;
      if (valid) got = 1'b1;
    end
    check({tag, ".lat"}, 32'(cyc), 32'(exp_lat));
    check({tag, ".hi"}, hi, exp_hi);
    check({tag, ".lo"}, lo, exp_lo);
    check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(exp_lat + 1));
    tick();
    check({tag, ".valid_off"}, {31'b0, valid}, 32'd0);
    check({tag, ".idle"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b1;
    cancel = 1'b0;
    op     = 2'b00;
    a      = 32'd5;
    b      = 32'd6;
    tick();
    tick();
    check("reset.busy", {31'b0, busy}, 32'd0);
    check("reset.valid", {31'b0, valid}, 32'd0);
    check("reset.hi", hi, 32'd0);
    check("reset.lo", lo, 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    tick();

    run_op("mult_neg", 2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1);
    run_op("multu", 2'b01, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 1);
    run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1);
    run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 32);
    run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32);
    run_op("div_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 32);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32);
    run_op("divu_max_1", 2'b11, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 32);
    run_op("div_by0", 2'b10, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1);
    run_op("divu_by0", 2'b11, 32'h0000_DEAD, 32'd0, 32'h0000_DEAD, 32'hFFFF_FFFF, 1);

    // start together with cancel in IDLE is dropped
    start  = 1'b1;
    cancel = 1'b1;
    op     = 2'b01;
    a      = 32'd9;
    b      = 32'd9;
    tick();
    start  = 1'b0;
    cancel = 1'b0;
    check("start_cancel.busy", {31'b0, busy}, 32'd0);
    tick();
    check("start_cancel.valid", {31'b0, valid}, 32'd0);
    check("start_cancel.lo", lo, 32'hFFFF_FFFF);

    // Abort a divide mid-flight; hi/lo keep the previous MULT result
    run_op("mult_pre", 2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1);
    start = 1'b1;
    op    = 2'b11;
    a     = 32'd100;
    b     = 32'd7;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel.busy", {31'b0, busy}, 32'd0);
    check("cancel.valid", {31'b0, valid}, 32'd0);
    check("cancel.hi", hi, 32'hFFFF_FFFF);
    check("cancel.lo", lo, 32'hFFFF_FFFA);
    run_op("after_cancel", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 32);

    // Held start: one result every three cycles, isolated valid pulses
    start = 1'b1;
    op    = 2'b01;
    a     = 32'd5;
    b     = 32'd6;
    tick();
    for (int i = 1; i <= 9; i++) begin
      tick();
      check($sformatf("held.valid%0d", i), {31'b0, valid}, (i % 3 == 1) ? 32'd1 : 32'd0);
      if (i % 3 == 1) check($sformatf("held.lo%0d", i), lo, 32'd30);
    end
    start = 1'b0;
    for (int i = 0; i < 4 && busy; i++) tick();
    check("held.idle", {31'b0, busy}, 32'd0);
    check("held.hi", hi, 32'd0);

    // Reset in the middle of a divide, with start held to show reset wins
    start = 1'b1;
    op    = 2'b10;
    a     = 32'd100;
    b     = 32'd7;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("middiv.busy", {31'b0, busy}, 32'd1);
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("rst_mid.busy", {31'b0, busy}, 32'd0);
    check("rst_mid.valid", {31'b0, valid}, 32'd0);
    check("rst_mid.hi", hi, 32'd0);
    check("rst_mid.lo", lo, 32'd0);
    tick();
    check("rst_mid.stays_idle", {31'b0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
